// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between two masters (m0 = cpu core,
// m1 = loader/DMA). Round-robin arbitration with one transaction in flight.
// Each access holds mem_en for WAIT_CYCLES+1 cycles, then pulses ready for
// one cycle to the granted master.
//
// Ports:
//   clock, reset              system clock, synchronous active-high reset
//   mX_req/rw/addr/wdata      master X request, direction (1=read), address, write data
//   mX_gnt                    master X owns the bus (ACCESS and DONE)
//   mX_ready                  one-cycle completion pulse for master X
//   rdata                     data of the last completed read (shared)
//   mem_en/rw/addr/wdata      memory access strobe, direction, address, write data
//   mem_rdata                 memory read data, valid on the last ACCESS cycle
//   busy                      arbiter is not idle
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_rw,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_ready,
    input  logic              m1_req,
    input  logic              m1_rw,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             last_grant;   // also identifies the current owner once granted
    logic             winner_c;

    // Winner selection: a lone requester wins; on a tie the master that
    // was not granted last wins.
    always_comb begin
        winner_c = 1'b0;
        if (m0_req && m1_req) begin
            winner_c = ~last_grant;
        end else if (m1_req) begin
            winner_c = 1'b1;
        end
    end

    // Arbitration / access sequencing FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            last_grant <= 1'b1;
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
            m0_ready   <= 1'b0;
            m1_ready   <= 1'b0;
            mem_en     <= 1'b0;
            mem_rw     <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        state      <= ACCESS;
                        busy       <= 1'b1;
                        mem_en     <= 1'b1;
                        last_grant <= winner_c;
                        wait_cnt   <= CNT_W'(WAIT_CYCLES);
                        m0_gnt     <= ~winner_c;
                        m1_gnt     <= winner_c;
                        if (winner_c) begin
                            mem_rw    <= m1_rw;
                            mem_addr  <= m1_addr;
                            mem_wdata <= m1_wdata;
                        end else begin
                            mem_rw    <= m0_rw;
                            mem_addr  <= m0_addr;
                            mem_wdata <= m0_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (wait_cnt == '0) begin
                        state    <= DONE;
                        mem_en   <= 1'b0;
                        m0_ready <= ~last_grant;
                        m1_ready <= last_grant;
                        if (mem_rw) begin
                            rdata <= mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    m0_gnt   <= 1'b0;
                    m1_gnt   <= 1'b0;
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with WAIT_CYCLES=2 and one
// with WAIT_CYCLES=0 share all inputs; each task checks its own outputs.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        m0_req, m0_rw, m1_req, m1_rw;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;

    // WAIT_CYCLES=2 instance outputs
    logic        m0_gnt, m0_ready, m1_gnt, m1_ready, mem_en, mem_rw, busy;
    logic [31:0] rdata, mem_addr, mem_wdata;

    // WAIT_CYCLES=0 instance outputs
    logic        z_m0_gnt, z_m0_ready, z_m1_gnt, z_m1_ready, z_mem_en, z_mem_rw, z_busy;
    logic [31:0] z_rdata, z_mem_addr, z_mem_wdata;

    int checks = 0;
    int passes = 0;

    mem_arbiter #(.WAIT_CYCLES(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_ready(m0_ready),
        .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_ready(m1_ready),
        .rdata(rdata), .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.WAIT_CYCLES(0), .ADDR_W(32), .DATA_W(32)) dut_z (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(z_m0_gnt), .m0_ready(z_m0_ready),
        .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(z_m1_gnt), .m1_ready(z_m1_ready),
        .rdata(z_rdata), .mem_en(z_mem_en), .mem_rw(z_mem_rw), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_rdata(mem_rdata), .busy(z_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m0_req = 1'b0; m0_rw = 1'b1; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_rw = 1'b1; m1_addr = '0; m1_wdata = '0;
        mem_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if ({m0_gnt, m1_gnt, m0_ready, m1_ready} !== 4'b0000) $display("FAIL reset_gnt_ready got=%b exp=0000", {m0_gnt, m1_gnt, m0_ready, m1_ready}); else passes++;
        checks++; if ({mem_en, busy, mem_rw} !== 3'b001) $display("FAIL reset_en_busy_rw got=%b exp=001", {mem_en, busy, mem_rw}); else passes++;
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) $display("FAIL reset_addr_wdata got=%h/%h exp=0/0", mem_addr, mem_wdata); else passes++;
        checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", rdata); else passes++;
    endtask

    task automatic test_m0_read();
        m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h10 || mem_rw !== 1'b1) $display("FAIL rd_access c%0d got en=%b addr=%h rw=%b exp en=1 addr=10 rw=1", c, mem_en, mem_addr, mem_rw); else passes++;
            checks++; if ({m0_gnt, m1_gnt, m0_ready, busy} !== 4'b1001) $display("FAIL rd_gnt c%0d got=%b exp=1001", c, {m0_gnt, m1_gnt, m0_ready, busy}); else passes++;
        end
        tick();
        checks++; if ({m0_ready, m0_gnt, m1_ready, mem_en} !== 4'b1100) $display("FAIL rd_done got=%b exp=1100", {m0_ready, m0_gnt, m1_ready, mem_en}); else passes++;
        checks++; if (rdata !== 32'hDEADBEEF) $display("FAIL rd_rdata got=%h exp=deadbeef", rdata); else passes++;
        m0_req = 1'b0;
        tick();
        checks++; if ({busy, m0_gnt, m0_ready} !== 3'b000) $display("FAIL rd_idle got=%b exp=000", {busy, m0_gnt, m0_ready}); else passes++;
    endtask

    task automatic test_m1_write();
        int pulses;
        pulses = 0;
        m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 32'h20; m1_wdata = 32'h1234; mem_rdata = 32'h5555_5555;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++; if (mem_en !== 1'b1 || mem_rw !== 1'b0 || mem_wdata !== 32'h1234 || mem_addr !== 32'h20) $display("FAIL wr_access c%0d got en=%b rw=%b wd=%h addr=%h exp 1/0/1234/20", c, mem_en, mem_rw, mem_wdata, mem_addr); else passes++;
            checks++; if ({m1_gnt, m0_gnt} !== 2'b10) $display("FAIL wr_gnt c%0d got=%b exp=10", c, {m1_gnt, m0_gnt}); else passes++;
            if (m1_ready === 1'b1) pulses++;
        end
        tick();
        if (m1_ready === 1'b1) pulses++;
        checks++; if ({m1_ready, m0_ready} !== 2'b10) $display("FAIL wr_done got=%b exp=10", {m1_ready, m0_ready}); else passes++;
        m1_req = 1'b0;
        tick();
        if (m1_ready === 1'b1) pulses++;
        checks++; if (pulses != 1) $display("FAIL wr_pulses got=%0d exp=1", pulses); else passes++;
        checks++; if (rdata !== 32'hDEADBEEF) $display("FAIL wr_rdata_hold got=%h exp=deadbeef", rdata); else passes++;
    endtask

    task automatic test_fairness();
        logic exp_m;
        m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 32'h100; m0_wdata = 32'hA0;
        m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 32'h200; m1_wdata = 32'hB1;
        for (int k = 0; k < 4; k++) begin
            exp_m = 1'(k % 2);
            for (int c = 1; c <= 5; c++) begin
                tick();
                checks++; if (m0_gnt === 1'b1 && m1_gnt === 1'b1) $display("FAIL rr_overlap k%0d c%0d both gnt high", k, c); else passes++;
                if (c <= 4) begin
                    checks++; if ({m1_gnt, m0_gnt} !== (exp_m ? 2'b10 : 2'b01)) $display("FAIL rr_gnt k%0d c%0d got m1/m0=%b exp m%0d", k, c, {m1_gnt, m0_gnt}, exp_m); else passes++;
                end
                if (c == 4) begin
                    checks++; if ({m1_ready, m0_ready} !== (exp_m ? 2'b10 : 2'b01)) $display("FAIL rr_ready k%0d got m1/m0=%b exp m%0d", k, {m1_ready, m0_ready}, exp_m); else passes++;
                end
                if (c == 5) begin
                    checks++; if ({busy, m0_gnt, m1_gnt} !== 3'b000) $display("FAIL rr_idle k%0d got=%b exp=000", k, {busy, m0_gnt, m1_gnt}); else passes++;
                end
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
    endtask

    task automatic test_ignore_changes();
        m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 32'h40; mem_rdata = 32'hA5A5A5A5;
        tick();
        m0_req = 1'b0; m0_rw = 1'b0; m0_addr = 32'h99;
        for (int c = 1; c <= 3; c++) begin
            checks++; if (mem_addr !== 32'h40 || mem_rw !== 1'b1 || mem_en !== 1'b1) $display("FAIL ign_hold c%0d got addr=%h rw=%b en=%b exp 40/1/1", c, mem_addr, mem_rw, mem_en); else passes++;
            tick();
        end
        checks++; if (m0_ready !== 1'b1) $display("FAIL ign_ready got=%b exp=1", m0_ready); else passes++;
        checks++; if (rdata !== 32'hA5A5A5A5) $display("FAIL ign_rdata got=%h exp=a5a5a5a5", rdata); else passes++;
        tick();
        checks++; if ({busy, m0_ready} !== 2'b00) $display("FAIL ign_idle got=%b exp=00", {busy, m0_ready}); else passes++;
    endtask

    task automatic test_reset_mid();
        m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 32'h50; m0_addr = 32'h50;
        tick();
        tick();
        reset = 1'b1; m0_req = 1'b0;
        tick();
        checks++; if ({mem_en, m0_gnt, m1_gnt, m0_ready, m1_ready, busy} !== 6'b0) $display("FAIL rst_mid_ctrl got=%b exp=000000", {mem_en, m0_gnt, m1_gnt, m0_ready, m1_ready, busy}); else passes++;
        checks++; if (rdata !== 32'h0 || mem_addr !== 32'h0 || mem_rw !== 1'b1) $display("FAIL rst_mid_data got rdata=%h addr=%h rw=%b exp 0/0/1", rdata, mem_addr, mem_rw); else passes++;
        m0_req = 1'b1; m1_req = 1'b1; m1_rw = 1'b1; m1_addr = 32'h60;
        tick();
        checks++; if ({m0_gnt, m1_gnt, mem_en} !== 3'b000) $display("FAIL rst_req_nogrant got=%b exp=000", {m0_gnt, m1_gnt, mem_en}); else passes++;
        reset = 1'b0;
        tick();
        checks++; if ({m0_gnt, m1_gnt, mem_en} !== 3'b101) $display("FAIL rst_tiebreak got=%b exp=101", {m0_gnt, m1_gnt, mem_en}); else passes++;
        checks++; if (mem_addr !== 32'h50) $display("FAIL rst_tiebreak_addr got=%h exp=50", mem_addr); else passes++;
        tick(); tick(); tick();
        checks++; if ({m0_ready, m1_ready} !== 2'b10) $display("FAIL rst_after_ready got=%b exp=10", {m0_ready, m1_ready}); else passes++;
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
    endtask

    task automatic test_wait0();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 32'h60; mem_rdata = 32'h0BADF00D;
        tick();
        checks++; if ({z_mem_en, z_m0_gnt, z_m0_ready} !== 3'b110 || z_mem_addr !== 32'h60) $display("FAIL w0_access got en/gnt/rdy=%b addr=%h exp 110/60", {z_mem_en, z_m0_gnt, z_m0_ready}, z_mem_addr); else passes++;
        tick();
        checks++; if ({z_m0_ready, z_m0_gnt, z_mem_en} !== 3'b110) $display("FAIL w0_done got=%b exp=110", {z_m0_ready, z_m0_gnt, z_mem_en}); else passes++;
        checks++; if (z_rdata !== 32'h0BADF00D) $display("FAIL w0_rdata got=%h exp=0badf00d", z_rdata); else passes++;
        m0_req = 1'b0;
        tick();
        checks++; if ({z_busy, z_m0_ready, z_mem_en} !== 3'b000) $display("FAIL w0_idle got=%b exp=000", {z_busy, z_m0_ready, z_mem_en}); else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_m0_read();
        test_m1_write();
        test_fairness();
        test_ignore_changes();
        test_reset_mid();
        test_wait0();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
